// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage RAW hazard tracker with per-source forward select
// Tracks recent writers in a shift register, youngest in entry 0; stalls while a needed result is still in flight.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int LAT_W  = 2,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_en,
  input  logic              id_rt_en,
  input  logic [ADDR_W-1:0] id_wd,
  input  logic              id_we,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [15:0]       stall_cnt
);

  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][LAT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]                  stall_cnt_q, stall_cnt_d;

  logic             rs_stall, rt_stall;
  logic [SEL_W-1:0] rs_sel, rt_sel;
  logic             ins_v;

  // Walk oldest to youngest so the youngest match overrides everything older.
  always_comb begin
    rs_stall = 1'b0;
    rt_stall = 1'b0;
    rs_sel   = '0;
    rt_sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (id_rs_en && (id_rs != '0) && v_q[i] && (addr_q[i] == id_rs)) begin
        rs_stall = (cnt_q[i] != '0);
        rs_sel   = SEL_W'(i + 1);
      end
      if (id_rt_en && (id_rt != '0) && v_q[i] && (addr_q[i] == id_rt)) begin
        rt_stall = (cnt_q[i] != '0);
        rt_sel   = SEL_W'(i + 1);
      end
    end
  end

  assign stall = ~rst & id_valid & ~flush & (rs_stall | rt_stall);

  // A source whose youngest match is not yet ready never forwards, even when flush masks the stall.
  assign fwd_rs_sel = (~rst & id_valid & ~stall & ~rs_stall) ? rs_sel : '0;
  assign fwd_rt_sel = (~rst & id_valid & ~stall & ~rt_stall) ? rt_sel : '0;

  assign ins_v = id_valid & id_we & (id_wd != '0) & ~stall & ~flush;

  always_comb begin
    v_d    = '0;
    addr_d = '0;
    cnt_d  = '0;
    v_d[0]    = ins_v;
    addr_d[0] = ins_v ? id_wd : '0;
    cnt_d[0]  = ins_v ? id_lat : '0;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]    = v_q[i-1] & ~flush;
      addr_d[i] = addr_q[i-1];
      cnt_d[i]  = (cnt_q[i-1] == '0) ? '0 : cnt_q[i-1] - LAT_W'(1);
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a writer-history model
// The model keeps every issued writer by issue edge; age and remaining latency follow from edge arithmetic.
module tb_hazard_scoreboard;
  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wd = '0;
  logic       id_rs_en = 1'b0, id_rt_en = 1'b0, id_we = 1'b0;
  logic [1:0] id_lat = '0;
  logic       flush = 1'b0;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [15:0] stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

  // Writer history: entry issued at edge e is alive if e > m_kill.
  bit   hv[int];
  int   ha[int];
  int   hl[int];
  int   m_n = 0;
  int   m_kill = 0;
  int   m_scnt = 0;
  bit   last_exp_stall = 0;

  hazard_scoreboard #(.ADDR_W(5), .DEPTH(DEPTH), .LAT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
    .id_wd(id_wd), .id_we(id_we), .id_lat(id_lat), .flush(flush),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endtask

  function automatic int src_sel(input int addr, input bit en, output bit st);
    st = 0;
    if (!en || addr == 0) return 0;
    for (int i = 0; i < DEPTH; i++) begin
      int e;
      e = m_n - i;
      if (e <= m_kill) return 0;
      if (hv.exists(e) && hv[e] && ha[e] == addr) begin
        if (hl[e] > i) begin
          st = 1;
          return 0;
        end
        return i + 1;
      end
    end
    return 0;
  endfunction

  task automatic model_eval(output bit es, output int ers, output int ert);
    bit sr, st;
    int a, b;
    a = src_sel(int'(id_rs), id_rs_en, sr);
    b = src_sel(int'(id_rt), id_rt_en, st);
    es  = !rst && id_valid && !flush && (sr || st);
    ers = (!rst && id_valid && !es) ? a : 0;
    ert = (!rst && id_valid && !es) ? b : 0;
  endtask

  always @(posedge clk) begin
    bit es;
    int ers, ert;
    model_eval(es, ers, ert);
    m_n++;
    if (rst) begin
      hv[m_n] = 0;
      m_kill = m_n;
      m_scnt = 0;
    end else begin
      hv[m_n] = id_valid && id_we && (id_wd != 0) && !flush && !es;
      ha[m_n] = int'(id_wd);
      hl[m_n] = int'(id_lat);
      if (flush) m_kill = m_n;
      if (es && m_scnt != 65535) m_scnt++;
    end
  end

  always @(negedge clk) begin
    bit es;
    int ers, ert;
    model_eval(es, ers, ert);
    last_exp_stall = es;
    chk("model_stall", int'(stall), int'(es));
    chk("model_fwd_rs", int'(fwd_rs_sel), ers);
    chk("model_fwd_rt", int'(fwd_rt_sel), ert);
    chk("model_stall_cnt", int'(stall_cnt), m_scnt);
  end

  task automatic set_in(input bit v, input int rs, input bit rse, input int rt, input bit rte,
                        input int wd, input bit we, input int lat, input bit fl);
    id_valid = v; id_rs = 5'(rs); id_rs_en = rse; id_rt = 5'(rt); id_rt_en = rte;
    id_wd = 5'(wd); id_we = we; id_lat = 2'(lat); flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1, 5, 1, 5, 1, 5, 1, 0, 0);
    @(negedge clk);
    chk("reset_stall", int'(stall), 0);
    chk("reset_fwd_rs", int'(fwd_rs_sel), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    #2 rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();

    // ALU back-to-back
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc(); set_in(1, 5, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu_stall", int'(stall), 0);
    chk("alu_fwd_rs", int'(fwd_rs_sel), 1);

    // Load-use: one stall cycle then forward from entry 1
    cyc(); set_in(1, 0, 0, 0, 0, 7, 1, 1, 0);
    cyc(); set_in(1, 0, 0, 7, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("load_use_stall", int'(stall), 1);
    chk("load_use_fwd_held", int'(fwd_rt_sel), 0);
    cyc();
    @(negedge clk);
    chk("load_use_release", int'(stall), 0);
    chk("load_use_fwd_rt", int'(fwd_rt_sel), 2);
    chk("load_use_stall_cnt", int'(stall_cnt), 1);

    // Youngest writer wins
    cyc(); set_in(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc(); set_in(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc(); set_in(1, 3, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("youngest_fwd_rs", int'(fwd_rs_sel), 1);

    // Retire after DEPTH non-writers; register 0 never hazards
    cyc(); set_in(1, 0, 0, 0, 0, 9, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(); set_in(1, 0, 0, 0, 0, 9, 0, 3, 0);
    end
    cyc(); set_in(1, 9, 1, 0, 0, 0, 1, 3, 0);
    @(negedge clk);
    chk("retired_fwd_rs", int'(fwd_rs_sel), 0);
    cyc(); set_in(1, 0, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_reg_stall", int'(stall), 0);
    chk("zero_reg_fwd_rs", int'(fwd_rs_sel), 0);

    // Flush during stall
    cyc(); set_in(1, 0, 0, 0, 0, 4, 1, 2, 0);
    cyc(); set_in(1, 4, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_pre_stall", int'(stall), 1);
    cyc(); set_in(1, 4, 1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush_stall", int'(stall), 0);
    cyc(); set_in(1, 4, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_flush_stall", int'(stall), 0);
    chk("post_flush_fwd_rs", int'(fwd_rs_sel), 0);
    chk("post_flush_stall_cnt", int'(stall_cnt), 2);

    // Async reset mid-stall
    cyc(); set_in(1, 0, 0, 0, 0, 4, 1, 3, 0);
    cyc(); set_in(1, 4, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("arst_pre_stall", int'(stall), 1);
    #1 rst = 1'b1; m_kill = m_n; m_scnt = 0;
    #1;
    chk("arst_stall", int'(stall), 0);
    chk("arst_fwd_rs", int'(fwd_rs_sel), 0);
    chk("arst_stall_cnt", int'(stall_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    set_in(1, 4, 1, 0, 0, 6, 1, 0, 0);
    #1;
    chk("arst_residual_stall", int'(stall), 0);
    chk("arst_residual_fwd", int'(fwd_rs_sel), 0);
    cyc(); set_in(1, 6, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("first_edge_insert_fwd", int'(fwd_rs_sel), 1);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (rst) rst = 1'b0;
      if (!(last_exp_stall && ($urandom % 4 != 0))) begin
        set_in(($urandom % 8) != 0, $urandom % 8, ($urandom % 4) != 0,
               $urandom % 8, ($urandom % 4) != 0, $urandom % 8,
               ($urandom % 2) != 0, $urandom % 4, ($urandom % 25) == 0);
      end
      if ($urandom % 300 == 0) begin
        #2 rst = 1'b1;
        m_kill = m_n;
        m_scnt = 0;
      end
    end
    cyc();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter ADDR_W, default 5, register address width.
REQ-002 SHALL provide parameter DEPTH, default 3, legal range 1..8, number of in-flight writer stages tracked.
REQ-003 SHALL provide parameter LAT_W, default 2, width of the result-latency field.
REQ-004 SHALL derive localparam SEL_W = clog2(DEPTH+1), the forward-select width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 id_valid  input  1  decode-stage instruction present.
REQ-008 id_rs, id_rt  input  ADDR_W each  source register addresses.
REQ-009 id_rs_en, id_rt_en  input  1 each  source actually read.
REQ-010 id_wd  input  ADDR_W  destination register address.
REQ-011 id_we  input  1  instruction writes id_wd.
REQ-012 id_lat  input  LAT_W  cycles after issue before the result is forwardable (0 = ALU, 1 = load, ...).
REQ-013 flush  input  1  kill all tracked in-flight writers.
REQ-014 stall  output  1  hold decode and insert a bubble this cycle.
REQ-015 fwd_rs_sel, fwd_rt_sel  output  SEL_W each  0 = register file, k = forward from tracked entry k-1.
REQ-016 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-017 SHALL hold DEPTH entries E[0..DEPTH-1], each {v, addr, cnt}; E[0] is the youngest writer.
REQ-018 Every cycle, E[i] SHALL move to E[i+1], with cnt decremented and saturating at 0; E[DEPTH-1] SHALL retire and be treated as visible in the register file.
REQ-019 On a non-stall, non-flush cycle, E[0] SHALL load {id_valid & id_we & (id_wd != 0), id_wd, id_lat}.
REQ-020 On a stall cycle, E[0] SHALL load a bubble {v=0}, and older entries SHALL still shift.
REQ-021 A source SHALL match entry i when its _en bit is set, the source address is nonzero, E[i].v = 1, and E[i].addr equals the source address.
REQ-022 Address 0 SHALL never match, stall, or forward.
REQ-023 For each source, only the lowest-index (youngest) matching entry SHALL be considered.
REQ-024 If that entry has cnt != 0, it SHALL raise a stall for that source.
REQ-025 If that entry has cnt = 0, the source's fwd_sel SHALL be i+1.
REQ-026 If no entry matches, fwd_sel SHALL be 0.
REQ-027 stall SHALL equal id_valid & ~flush & (rs_stall | rt_stall), purely combinational from current state and inputs.
REQ-028 fwd_*_sel SHALL be 0 whenever stall is 1 or id_valid is 0.
REQ-029 flush SHALL clear v in all entries at the next edge and SHALL suppress E[0] insertion; flush wins over stall.
REQ-030 stall_cnt SHALL increment by 1 on each edge where stall = 1, and saturate at 16'hFFFF.
REQ-031 A stalled instruction re-presented with unchanged inputs SHALL eventually proceed, within at most id_lat(max) stall cycles of the blocking writer.
REQ-032 Outputs SHALL have zero-cycle latency relative to the id_* inputs; the state update latency SHALL be one cycle.

Reset
REQ-033 While rst is high, SHALL asynchronously clear all E[i].v, addr, cnt and stall_cnt to 0.
REQ-034 While rst is high, stall SHALL be 0 and fwd_rs_sel / fwd_rt_sel SHALL be 0.
REQ-035 Reset asserted mid-stall SHALL abandon the stall with no residual entries after release.
REQ-036 The first edge after rst deasserts SHALL perform a normal insertion.

Verification
REQ-037 ALU back-to-back (DEPTH=3): issue wd=5, we=1, lat=0; next cycle rs=5, rs_en=1 -> stall=0, fwd_rs_sel=1.
REQ-038 Load-use: issue wd=7, lat=1; next cycle rt=7 -> stall=1 for exactly one cycle, then fwd_rt_sel=2, stall_cnt=1.
REQ-039 Youngest wins: writers to r3 issued in two consecutive cycles, both lat=0; then rs=3 -> fwd_rs_sel=1 (not 2).
REQ-040 Retire and zero register: writer r9 followed by DEPTH non-writers, then rs=9 -> fwd_rs_sel=0; any rs=0 -> stall=0 and fwd_rs_sel=0.
REQ-041 Flush during stall: load r4 with lat=2, then rs=4 stalling, assert flush -> stall=0 that cycle; next cycle rs=4 -> stall=0 and fwd_rs_sel=0.
REQ-042 Async reset: assert rst between clock edges with entries valid -> stall and fwd_*_sel go 0 immediately; stall_cnt = 0.
